// File: rtl/shift_deserializer_rx.sv
// shift_deserializer_rx: LSB-first serial-to-parallel receiver with a 1-entry valid/ready output buffer.
// Define PARITY_CHECK_EN to take a trailing even-parity bit per word and pulse parity_err on mismatch.
module shift_deserializer_rx #(
  parameter int WIDTH = 30,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  output logic             busy,
  output logic             parity_err
);
  typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] shreg_q, shreg_d, dout_q;
  logic [CNT_W-1:0] count_q, cnt_inc_d;
  logic             full_q, dv_q, ovr_q;
`ifdef PARITY_CHECK_EN
  logic             par_q, perr_q;
  assign parity_err = perr_q;
  assign busy       = state_q == RECV || state_q == PAR;
`else
  assign parity_err = 1'b0;
  assign busy       = state_q == RECV;
`endif
  assign shreg_d    = {bit_in, shreg_q[WIDTH-1:1]};
  assign cnt_inc_d  = count_q + 1'b1;
  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign overrun    = ovr_q;
  // full_q marks the cycle after the final bit; the word moves to the output stage on the following edge.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      ovr_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q <= 1'b0;
`endif
      if (dv_q && data_ready) dv_q <= 1'b0;
      if (full_q) begin
        full_q  <= 1'b0;
        count_q <= '0;
        state_q <= IDLE;
        if (!dv_q || data_ready) begin
          dout_q <= shreg_q;
          dv_q   <= 1'b1;
        end else ovr_q <= 1'b1;
`ifdef PARITY_CHECK_EN
        perr_q <= ^{shreg_q, par_q};
`endif
        if (bit_valid && frame_start) begin
          shreg_q <= shreg_d;
          count_q <= CNT_W'(1);
          state_q <= RECV;
        end
      end else if (bit_valid && frame_start) begin
        shreg_q <= shreg_d;
        count_q <= CNT_W'(1);
        state_q <= RECV;
      end else if (bit_valid && state_q == RECV) begin
        shreg_q <= shreg_d;
        count_q <= cnt_inc_d;
`ifdef PARITY_CHECK_EN
        if (cnt_inc_d == CNT_W'(WIDTH)) state_q <= PAR;
      end else if (bit_valid && state_q == PAR) begin
        par_q  <= bit_in;
        full_q <= 1'b1;
`else
        if (cnt_inc_d == CNT_W'(WIDTH)) full_q <= 1'b1;
`endif
      end
    end
endmodule
